// File: rtl/race_sequencer.sv
// Race controller: frame-tick detection, per-frame datapath strobe schedule,
// race state machine (idle/countdown/race/finished), checkpoint and lap tracking.
module race_sequencer #(
    parameter int FRAME_H          = 1200,
    parameter int FRAME_V          = 800,
    parameter int FRAMES_PER_COUNT = 60,
    parameter int LAPS_TO_WIN      = 3,
    parameter int TRACK_LO         = 56,
    parameter int TRACK_HI         = 1992,
    parameter int CP_SIZE          = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        start,
    input  logic        opp_finished,
    input  logic        opp_rst,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    output logic        frame_tick,
    output logic        trig_req,
    output logic        vel_en,
    output logic        coll_en,
    output logic        pos_en,
    output logic        move_en,
    output logic [1:0]  countdown_val,
    output logic [2:0]  lap_count,
    output logic [1:0]  race_state,
    output logic [2:0]  game_stat
);

    typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, RACE = 2'd2, FINISHED = 2'd3} state_t;

    localparam logic [10:0] LO_MIN = 11'(TRACK_LO);
    localparam logic [10:0] LO_MAX = 11'(TRACK_LO + CP_SIZE);
    localparam logic [10:0] HI_MIN = 11'(TRACK_HI - CP_SIZE);
    localparam logic [10:0] HI_MAX = 11'(TRACK_HI);
    localparam logic [2:0]  LAPS   = 3'(LAPS_TO_WIN);
    localparam int          CNT_W  = (FRAMES_PER_COUNT > 1) ? $clog2(FRAMES_PER_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_COUNT - 1);

    function automatic logic in_box(input logic [1:0] idx, input logic [10:0] x, input logic [10:0] y);
        logic x_lo, x_hi, y_lo, y_hi;
        x_lo = (x >= LO_MIN) && (x <= LO_MAX);
        x_hi = (x >= HI_MIN) && (x <= HI_MAX);
        y_lo = (y >= LO_MIN) && (y <= LO_MAX);
        y_hi = (y >= HI_MIN) && (y <= HI_MAX);
        case (idx)
            2'd0:    return x_lo && y_lo;
            2'd1:    return x_hi && y_lo;
            2'd2:    return x_hi && y_hi;
            default: return x_lo && y_hi;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             start_q, rise, win;
    logic             hit_p0, race_nxt;
    logic             vld_p1, vld_p2, vld_p3, vld_p4;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [1:0]       cd_d, cp_q, cp_d;
    logic [2:0]       lap_d, stat_d;
    logic             move_d;

    assign hit_p0     = (hcount == 11'(FRAME_H)) && (vcount == 10'(FRAME_V));
    assign rise       = start && !start_q;
    assign race_nxt   = (state_d == RACE);
    assign race_state = state_q;

    always_comb begin
        state_d = state_q;
        cd_d    = countdown_val;
        fcnt_d  = fcnt_q;
        lap_d   = lap_count;
        cp_d    = cp_q;
        stat_d  = game_stat;
        move_d  = move_en;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = COUNTDOWN;
                    cd_d    = 2'd3;
                    fcnt_d  = '0;
                end
            end
            COUNTDOWN: begin
                if (frame_tick) begin
                    if (fcnt_q == CNT_LAST) begin
                        fcnt_d = '0;
                        cd_d   = countdown_val - 2'd1;
                        if (countdown_val == 2'd1) begin
                            state_d = RACE;
                            move_d  = 1'b1;
                        end
                    end else begin
                        fcnt_d = fcnt_q + CNT_W'(1);
                    end
                end
            end
            RACE: begin
                // Only the expected box counts; wrapping from c0 back to c1 closes a lap.
                if (pos_en && in_box(cp_q, player_x, player_y)) begin
                    cp_d = cp_q + 2'd1;
                    if (cp_q == 2'd0 && lap_count < LAPS)
                        lap_d = lap_count + 3'd1;
                end
                win = (lap_d == LAPS);
                if (win || opp_finished) begin
                    state_d = FINISHED;
                    move_d  = 1'b0;
                    stat_d  = (win && opp_finished) ? 3'd3 : (win ? 3'd1 : 3'd2);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            frame_tick    <= 1'b0;
            trig_req      <= 1'b0;
            vel_en        <= 1'b0;
            coll_en       <= 1'b0;
            pos_en        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            vld_p3        <= 1'b0;
            vld_p4        <= 1'b0;
            fcnt_q        <= '0;
            countdown_val <= 2'd3;
            lap_count     <= 3'd0;
            cp_q          <= 2'd1;
            game_stat     <= 3'd0;
            move_en       <= 1'b0;
        end else if (opp_rst) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            frame_tick    <= 1'b0;
            trig_req      <= 1'b0;
            vel_en        <= 1'b0;
            coll_en       <= 1'b0;
            pos_en        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            vld_p3        <= 1'b0;
            vld_p4        <= 1'b0;
            fcnt_q        <= '0;
            countdown_val <= 2'd3;
            lap_count     <= 3'd0;
            cp_q          <= 2'd1;
            game_stat     <= 3'd0;
            move_en       <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            fcnt_q        <= fcnt_d;
            countdown_val <= cd_d;
            lap_count     <= lap_d;
            cp_q          <= cp_d;
            game_stat     <= stat_d;
            move_en       <= move_d;
            // Stage T+1: frame pulse; a phase sequence starts only while racing.
            frame_tick    <= hit_p0;
            trig_req      <= hit_p0 && race_nxt;
            vld_p1        <= hit_p0 && race_nxt;
            // Stages T+2..T+5: ROM latency, then velocity, collision, commit.
            vld_p2        <= vld_p1;
            vld_p3        <= vld_p2;
            vld_p4        <= vld_p3;
            vel_en        <= vld_p2 && race_nxt;
            coll_en       <= vld_p3 && race_nxt;
            pos_en        <= vld_p4 && race_nxt;
        end
    end

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer with a cycle-level behavioural model
// compared against every output on each falling clock edge.
module tb_race_sequencer;

    localparam int FPC  = 2;
    localparam int LAPS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        start = 1'b0, opp_finished = 1'b0, opp_rst = 1'b0;
    logic [10:0] player_x = '0, player_y = '0;
    logic        frame_tick, trig_req, vel_en, coll_en, pos_en, move_en;
    logic [1:0]  countdown_val, race_state;
    logic [2:0]  lap_count, game_stat;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    race_sequencer #(.FRAMES_PER_COUNT(FPC)) dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .start(start), .opp_finished(opp_finished), .opp_rst(opp_rst),
        .player_x(player_x), .player_y(player_y),
        .frame_tick(frame_tick), .trig_req(trig_req), .vel_en(vel_en),
        .coll_en(coll_en), .pos_en(pos_en), .move_en(move_en),
        .countdown_val(countdown_val), .lap_count(lap_count),
        .race_state(race_state), .game_stat(game_stat)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0, m_hit_t = -100;
    int m_state = 0, m_cd = 3, m_ticks = 0, m_lap = 0, m_cp = 1, m_stat = 0;
    bit m_move = 0, m_ft = 0, m_trig = 0, m_vel = 0, m_coll = 0, m_pos = 0, m_start_q = 0;

    function automatic bit in_rng(int v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Boxes: low span 56..456, high span 1592..1992.
    function automatic bit box_hit(int idx, int x, int y);
        bit xl, xh, yl, yh;
        xl = in_rng(x, 56, 456);   xh = in_rng(x, 1592, 1992);
        yl = in_rng(y, 56, 456);   yh = in_rng(y, 1592, 1992);
        case (idx)
            0: return xl && yl;
            1: return xh && yl;
            2: return xh && yh;
            default: return xl && yh;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int s, cd, tk, lap, cp, st, ht;
        bit mv, hit, rise, win, sq;
        if (!rst_n) begin
            m_state <= 0; m_cd <= 3; m_ticks <= 0; m_lap <= 0; m_cp <= 1; m_stat <= 0;
            m_move <= 0; m_ft <= 0; m_trig <= 0; m_vel <= 0; m_coll <= 0; m_pos <= 0;
            m_start_q <= 0; m_hit_t <= -100;
        end else begin
            s = m_state; cd = m_cd; tk = m_ticks; lap = m_lap; cp = m_cp; st = m_stat;
            mv = m_move; ht = m_hit_t; sq = start;
            hit  = (hcount == 11'd1200) && (vcount == 10'd800);
            rise = start && !m_start_q;
            if (opp_rst) begin
                s = 0; cd = 3; tk = 0; lap = 0; cp = 1; st = 0; mv = 0; ht = -100; hit = 0; sq = 0;
            end else begin
                case (m_state)
                    0: if (rise) begin s = 1; tk = 0; cd = 3; end
                    1: if (m_ft) begin
                        tk = tk + 1;
                        cd = 3 - tk / FPC;
                        if (tk == 3 * FPC) begin s = 2; mv = 1; cd = 0; end
                    end
                    2: begin
                        if (m_pos && box_hit(m_cp, int'(player_x), int'(player_y))) begin
                            if (m_cp == 0 && lap < LAPS) lap = lap + 1;
                            cp = (m_cp + 1) % 4;
                        end
                        win = (lap == LAPS);
                        if (win || opp_finished) begin
                            s = 3; mv = 0;
                            st = win ? (opp_finished ? 3 : 1) : 2;
                        end
                    end
                    default: ;
                endcase
            end
            if (hit && s == 2) ht = cyc;
            m_ft      <= hit;
            m_trig    <= (s == 2) && (ht == cyc);
            m_vel     <= (s == 2) && (ht == cyc - 2);
            m_coll    <= (s == 2) && (ht == cyc - 3);
            m_pos     <= (s == 2) && (ht == cyc - 4);
            m_state <= s; m_cd <= cd; m_ticks <= tk; m_lap <= lap; m_cp <= cp; m_stat <= st;
            m_move <= mv; m_hit_t <= ht; m_start_q <= sq;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("frame_tick", frame_tick, m_ft);
            cmp("trig_req", trig_req, m_trig);
            cmp("vel_en", vel_en, m_vel);
            cmp("coll_en", coll_en, m_coll);
            cmp("pos_en", pos_en, m_pos);
            cmp("move_en", move_en, m_move);
            cmp("countdown_val", countdown_val, m_cd);
            cmp("lap_count", lap_count, m_lap);
            cmp("race_state", race_state, m_state);
            cmp("game_stat", game_stat, m_stat);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic race_frame(input int px, input int py, input bit opp_at_pos,
                              input bit detail, input bit racing);
        player_x = 11'(px); player_y = 11'(py);
        hcount = 11'd1200; vcount = 10'd800;
        step(1);
        hcount = 11'd0; vcount = 10'd0;
        for (int k = 1; k <= 7; k++) begin
            if (detail) begin
                cmp("d_frame_tick", frame_tick, (k == 1));
                cmp("d_trig_req", trig_req, racing && (k == 1));
                cmp("d_vel_en", vel_en, racing && (k == 3));
                cmp("d_coll_en", coll_en, racing && (k == 4));
                cmp("d_pos_en", pos_en, racing && (k == 5));
            end
            if (k == 5 && opp_at_pos) opp_finished = 1'b1;
            step(1);
            opp_finished = 1'b0;
        end
        step(2);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0; step(1);
    endtask

    task automatic go_race();
        pulse_start();
        for (int i = 0; i < 6; i++) race_frame(0, 0, 0, 0, 0);
    endtask

    task automatic do_lap();
        race_frame(1800, 200, 0, 0, 1);
        race_frame(1800, 1800, 0, 0, 1);
        race_frame(200, 1800, 0, 0, 1);
        race_frame(200, 200, 0, 0, 1);
    endtask

    task automatic pulse_opp_rst();
        opp_rst = 1'b1; step(1); opp_rst = 1'b0;
        cmp("opp_rst_state", race_state, 0);
        cmp("opp_rst_lap", lap_count, 0);
        cmp("opp_rst_stat", game_stat, 0);
        cmp("opp_rst_cd", countdown_val, 3);
        step(1);
    endtask

    int cd_tab[6] = '{3, 2, 2, 1, 1, 0};

    initial begin
        step(2);
        chk_on = 1'b1;
        cmp("rst_state", race_state, 0);
        cmp("rst_cd", countdown_val, 3);
        cmp("rst_lap", lap_count, 0);
        cmp("rst_move", move_en, 0);
        rst_n = 1'b1;
        step(2);

        // IDLE: only frame_tick
        race_frame(0, 0, 0, 1, 0);

        // countdown with two frames per digit
        pulse_start();
        cmp("cd_entered", race_state, 1);
        for (int i = 0; i < 6; i++) begin
            race_frame(0, 0, 0, 0, 0);
            cmp("cd_step", countdown_val, cd_tab[i]);
        end
        cmp("race_state_after_cd", race_state, 2);
        cmp("move_after_cd", move_en, 1);

        // out-of-order boxes, with full phase schedule check
        race_frame(200, 200, 0, 1, 1);
        cmp("ooo_lap_a", lap_count, 0);
        race_frame(200, 1800, 0, 0, 1);
        cmp("ooo_lap_b", lap_count, 0);
        for (int l = 1; l <= 3; l++) begin
            do_lap();
            cmp("lap_count", lap_count, l);
        end
        cmp("win_state", race_state, 3);
        cmp("win_stat", game_stat, 1);
        cmp("win_move", move_en, 0);

        // FINISHED ignores start and frames
        pulse_start(); pulse_start();
        race_frame(0, 0, 0, 1, 0);
        cmp("fin_hold_state", race_state, 3);
        cmp("fin_hold_lap", lap_count, 3);
        pulse_opp_rst();

        // opp_finished ignored in COUNTDOWN, loses in RACE
        pulse_start();
        opp_finished = 1'b1; step(3); opp_finished = 1'b0;
        cmp("cd_opp_ignored", race_state, 1);
        cmp("cd_opp_stat", game_stat, 0);
        for (int i = 0; i < 6; i++) race_frame(0, 0, 0, 0, 0);
        do_lap();
        cmp("lose_lap", lap_count, 1);
        opp_finished = 1'b1; step(1); opp_finished = 1'b0;
        cmp("lose_state", race_state, 3);
        cmp("lose_stat", game_stat, 2);
        cmp("lose_move", move_en, 0);
        pulse_opp_rst();

        // tie: opp_finished in the pos_en cycle completing lap 3
        go_race();
        do_lap(); do_lap();
        race_frame(1800, 200, 0, 0, 1);
        race_frame(1800, 1800, 0, 0, 1);
        race_frame(200, 1800, 0, 0, 1);
        race_frame(200, 200, 1, 0, 1);
        cmp("tie_state", race_state, 3);
        cmp("tie_stat", game_stat, 3);
        cmp("tie_lap", lap_count, 3);
        pulse_opp_rst();

        // async reset in the middle of a phase sequence
        go_race();
        hcount = 11'd1200; vcount = 10'd800;
        step(1);
        hcount = 11'd0; vcount = 10'd0;
        cmp("ar_trig", trig_req, 1);
        step(1);
        #1 rst_n = 1'b0;
        #1;
        cmp("ar_state", race_state, 0);
        cmp("ar_cd", countdown_val, 3);
        cmp("ar_move", move_en, 0);
        step(3);
        rst_n = 1'b1;
        step(8);
        cmp("ar_after_state", race_state, 0);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
Top-level game controller that sequences the per-frame kart update datapath: trig ROM fetch, velocity compute, collision check and position commit.
Owns the race state machine (idle, countdown, race, finished) and checkpoint/lap tracking.
Produces the win/lose/tie status exported over the link.
Sits between the video timing counters and the kart physics block, which acts only on this block's strobes.

Parameters:
FRAME_H, 1200, hcount value that marks the once-per-frame update point
FRAME_V, 800, vcount value that marks the update point
FRAMES_PER_COUNT, 60, frame ticks per countdown digit
LAPS_TO_WIN, 3, completed laps that end the race
TRACK_LO, 56, low edge of the corner checkpoint boxes
TRACK_HI, 1992, high edge of the corner checkpoint boxes
CP_SIZE, 400, checkpoint box side length

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hcount  in  11  pixel column
vcount  in  10  pixel row
start  in  1  race start button, already debounced/synchronised, level
opp_finished  in  1  peer reports its race is over (from link)
opp_rst  in  1  peer reset request (from link), level
player_x  in  11  current player x, unsigned
player_y  in  11  current player y, unsigned
frame_tick  out  1  one-cycle pulse per frame, all states
trig_req  out  1  strobe: present direction to sin/cos ROMs
vel_en  out  1  strobe: latch increments from ROM outputs
coll_en  out  1  strobe: evaluate kart overlap
pos_en  out  1  strobe: commit new positions
move_en  out  1  level: steering/motion permitted
countdown_val  out  2  digit shown on the start lights (3,2,1,0)
lap_count  out  3  completed laps
race_state  out  2  0 IDLE, 1 COUNTDOWN, 2 RACE, 3 FINISHED
game_stat  out  3  0 racing/none, 1 won, 2 lost, 3 tie

Behaviour:
- Reset (rst_n low, async): race_state=IDLE, every strobe 0, move_en=0, countdown_val=3, lap_count=0, game_stat=0, expected checkpoint=1, start edge register=0. All outputs are registered.
- Frame detect: let T be the cycle in which hcount==FRAME_H && vcount==FRAME_V. frame_tick is high in T+1 only.
- Phase schedule, RACE only: trig_req at T+1, vel_en at T+3 (2-cycle ROM latency), coll_en at T+4, pos_en at T+5. Each strobe is exactly one cycle. In other states these four strobes stay 0.
- Once started, a phase sequence always completes, unless the state leaves RACE first; the remaining strobes of that sequence are then suppressed.
- start edge: rise = start && !start_q.
- IDLE: on rise, go to COUNTDOWN with countdown_val=3 and the frame counter cleared.
- COUNTDOWN: a frame counter counts frame_ticks. At FRAMES_PER_COUNT ticks the counter clears and countdown_val decrements.
  - When countdown_val is 1 and the count expires: countdown_val=0, go to RACE, move_en=1 from the next cycle.
- RACE: checkpoints are evaluated only in the pos_en cycle, using player_x/player_y as sampled that cycle.
  - Box c0 = x,y in [TRACK_LO, TRACK_LO+CP_SIZE].
  - Box c1 = x in [TRACK_HI-CP_SIZE, TRACK_HI], y as c0.
  - Box c2 = x,y in [TRACK_HI-CP_SIZE, TRACK_HI].
  - Box c3 = x as c0, y as c2.
  - All bounds are inclusive.
  - Only the expected box counts; the expected index advances 1→2→3→0→1.
  - Entering c0 while c0 is expected increments lap_count.
- RACE exit:
  - lap_count reaching LAPS_TO_WIN → FINISHED, game_stat=1.
  - opp_finished high in any RACE cycle → FINISHED, game_stat=2.
  - Both in the same cycle → game_stat=3.
  - Entering FINISHED drops move_en in the same clock edge.
- FINISHED: all outputs hold. start is ignored. Exit only via rst_n or opp_rst.
- opp_rst, synchronous, any state, highest priority after rst_n: all registers return to their reset values, taking effect on the next edge.
- opp_finished in IDLE or COUNTDOWN is ignored.
- rst_n asserted mid-sequence aborts immediately. No strobe may glitch high after reset release until a new T is observed.
- lap_count saturates at LAPS_TO_WIN and never wraps.

Test Plan:
1. FRAMES_PER_COUNT=2. Pulse start, then drive 6 frames → countdown_val steps 3,3,2,2,1,1 per frame, then 0. race_state=2 and move_en=1 after the 6th frame_tick.
2. In RACE, hcount=1200, vcount=800 at cycle T → trig_req@T+1, vel_en@T+3, coll_en@T+4, pos_en@T+5, each exactly one cycle. In IDLE, only frame_tick@T+1.
3. Drive player (1800,200), (1800,1800), (200,1800), (200,200) on successive pos_en cycles, three times → lap_count 1,2,3, then race_state=3, game_stat=1. Out-of-order box visits do not change lap_count.
4. Raise opp_finished during RACE with lap_count=1 → next cycle race_state=3, game_stat=2, move_en=0. The same stimulus during COUNTDOWN → no effect.
5. Raise opp_finished in the same pos_en cycle that completes lap 3 → game_stat=3.
6. In FINISHED, start toggles → no change. Assert opp_rst → next cycle race_state=0, lap_count=0, game_stat=0. Deassert rst_n at T+2 in RACE → vel_en/coll_en/pos_en stay 0 and all outputs are at reset values asynchronously.
